// File: rtl/decap_packet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decap_packet_pkg
// Purpose  : Shared widths, header layout and FSM states for Aurora encap/decap
// Revision : 1.0 - initial release
// ============================================================================
package decap_packet_pkg;

    localparam int DATA_WIDTH             = 1024;
    localparam int ADDR_WIDTH             = 10;
    localparam int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH;
    localparam int RECOGNIZE_ROUTER_WIDTH = 2;
    localparam int NUMBER_PACKET          = 19;
    localparam int TTL_WIDTH              = $clog2(3);
    localparam int IDX_WIDTH              = $clog2(NUMBER_PACKET);
    localparam int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + IDX_WIDTH + TTL_WIDTH;
    localparam int AURORA_DATA_WIDTH      = 64;
    localparam int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH;

    // Header sits directly above the payload: [63:62] id, [61:57] idx, [56:55] ttl
    localparam int HDR_LSB = PAYLOAD_WIDTH;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUMBER_PACKET - 1);

    typedef struct packed {
        logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id;
        logic [IDX_WIDTH-1:0]              pkt_idx;
        logic [TTL_WIDTH-1:0]              ttl;
    } header_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    function automatic header_t get_header(input logic [AURORA_DATA_WIDTH-1:0] word);
        return header_t'(word[AURORA_DATA_WIDTH-1:HDR_LSB]);
    endfunction

    function automatic logic [PAYLOAD_WIDTH-1:0] get_payload(input logic [AURORA_DATA_WIDTH-1:0] word);
        return word[PAYLOAD_WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/decap_packet_if.sv
`default_nettype none
// ============================================================================
// Module   : decap_packet_if
// Purpose  : Link-word input and reassembled DFX-word output handshake bundle
// Revision : 1.0 - initial release
// ============================================================================
interface decap_packet_if;
    import decap_packet_pkg::*;

    logic [AURORA_DATA_WIDTH-1:0] data_out_port_0;
    logic                         data_out_valid;
    logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv;
    logic [HEADER_WIDTH-1:0]      header_pkt_recv;
    logic                         data_dfx_valid;
    logic                         data_dfx_ready;

    // master = decapsulator, slave = link source plus downstream DFX writer
    modport master (
        input  data_out_port_0,
        input  data_out_valid,
        input  data_dfx_ready,
        output data_dfx_recv,
        output header_pkt_recv,
        output data_dfx_valid
    );

    modport slave (
        output data_out_port_0,
        output data_out_valid,
        output data_dfx_ready,
        input  data_dfx_recv,
        input  header_pkt_recv,
        input  data_dfx_valid
    );

endinterface
`default_nettype wire

// File: rtl/decap_slice_store.sv
`default_nettype none
// ============================================================================
// Module   : decap_slice_store
// Purpose  : 19-slice assembly register; slice k lands at bits [k*55 +: 55]
// Revision : 1.0 - initial release
// ============================================================================
module decap_slice_store
    import decap_packet_pkg::*;
(
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      wr_en,
    input  wire logic [IDX_WIDTH-1:0]      wr_idx,
    input  wire logic [PAYLOAD_WIDTH-1:0]  wr_data,
    output logic      [DATA_DFX_WIDTH-1:0] data_dfx
);

    generate
        for (genvar k = 0; k < NUMBER_PACKET; k++) begin : g_slice
            localparam logic [IDX_WIDTH-1:0] c_slice_idx = IDX_WIDTH'(k);
            // The last slice only carries the 44 bits left over above 18*55
            localparam int c_width = (k == NUMBER_PACKET - 1) ?
                                     (DATA_DFX_WIDTH - k * PAYLOAD_WIDTH) : PAYLOAD_WIDTH;

            logic [c_width-1:0] r_slice;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_slice <= '0;
                end else if (wr_en && (wr_idx == c_slice_idx)) begin
                    r_slice <= wr_data[c_width-1:0];
                end
            end

            assign data_dfx[k*PAYLOAD_WIDTH +: c_width] = r_slice;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/decap_packet.sv
`default_nettype none
// ============================================================================
// Module   : decap_packet
// Purpose  : Reassembles 19 Aurora slices into one DFX word, flags sequencing
// Revision : 1.0 - initial release
// ============================================================================
module decap_packet
    import decap_packet_pkg::*;
(
    input  wire logic                              clk,
    input  wire logic                              rst_n,
    input  wire logic [RECOGNIZE_ROUTER_WIDTH-1:0] local_router_id,
    decap_packet_if.master                         bus,
    output logic                                   frame_err,
    output logic                                   overflow_err
);

    state_t                 r_state;
    logic [IDX_WIDTH-1:0]   r_exp_idx;
    header_t                r_header;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overflow_err;

    header_t                w_hdr;
    logic [PAYLOAD_WIDTH-1:0] w_payload;
    logic                   w_match;
    logic                   w_first;
    logic                   w_handshake;
    logic                   w_store_en;

    assign w_hdr       = get_header(bus.data_out_port_0);
    assign w_payload   = get_payload(bus.data_out_port_0);
    assign w_match     = bus.data_out_valid && (w_hdr.router_id == local_router_id);
    assign w_first     = (w_hdr.pkt_idx == '0);
    assign w_handshake = r_valid && bus.data_dfx_ready;

    // The assembly register is only written while no complete frame is on show,
    // except for an idx-0 word that arrives together with the releasing handshake.
    always_comb begin
        w_store_en = 1'b0;
        case (r_state)
            ST_IDLE:    w_store_en = w_match && w_first;
            ST_COLLECT: w_store_en = w_match && (w_first || (w_hdr.pkt_idx == r_exp_idx));
            ST_FULL:    w_store_en = w_match && w_first && w_handshake;
            default:    w_store_en = 1'b0;
        endcase
    end

    decap_slice_store u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (w_store_en),
        .wr_idx   (w_hdr.pkt_idx),
        .wr_data  (w_payload),
        .data_dfx (bus.data_dfx_recv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_exp_idx      <= '0;
            r_header       <= '0;
            r_valid        <= 1'b0;
            r_frame_err    <= 1'b0;
            r_overflow_err <= 1'b0;
        end else begin
            r_frame_err    <= 1'b0;
            r_overflow_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_match) begin
                        if (w_first) begin
                            r_header  <= w_hdr;
                            r_exp_idx <= IDX_WIDTH'(1);
                            r_state   <= ST_COLLECT;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (w_match) begin
                        if (w_hdr.pkt_idx == r_exp_idx) begin
                            r_exp_idx <= r_exp_idx + 1'b1;
                            if (w_hdr.pkt_idx == LAST_IDX) begin
                                r_state <= ST_FULL;
                                r_valid <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            if (w_first) begin
                                r_header  <= w_hdr;
                                r_exp_idx <= IDX_WIDTH'(1);
                            end else begin
                                r_exp_idx <= '0;
                                r_state   <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_FULL: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        if (w_match && w_first) begin
                            r_header  <= w_hdr;
                            r_exp_idx <= IDX_WIDTH'(1);
                            r_state   <= ST_COLLECT;
                        end else begin
                            // A non-zero slice at release time is out of sequence for IDLE
                            r_frame_err <= w_match;
                            r_exp_idx   <= '0;
                            r_state     <= ST_IDLE;
                        end
                    end else if (w_match) begin
                        r_overflow_err <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_exp_idx <= '0;
                    r_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.header_pkt_recv = r_header;
    assign bus.data_dfx_valid  = r_valid;
    assign frame_err           = r_frame_err;
    assign overflow_err        = r_overflow_err;

endmodule
`default_nettype wire

// File: tb/tb_decap_packet.sv
`default_nettype none
// ============================================================================
// Module   : tb_decap_packet
// Purpose  : Randomized self-checking bench for the Aurora slice reassembler
// Revision : 1.0 - initial release
// ============================================================================
module tb_decap_packet;
    import decap_packet_pkg::*;

    typedef logic [DATA_DFX_WIDTH-1:0]    dfx_t;
    typedef logic [AURORA_DATA_WIDTH-1:0] word_t;
    typedef logic [HEADER_WIDTH-1:0]      hdr_t;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0] local_router_id;
    logic                              frame_err;
    logic                              overflow_err;

    decap_packet_if bus();

    decap_packet dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .local_router_id (local_router_id),
        .bus             (bus),
        .frame_err       (frame_err),
        .overflow_err    (overflow_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe0, ov0;

    // Pulse monitor: a stuck-high error line counts once per cycle
    always @(negedge clk) begin
        if (frame_err === 1'b1)    fe_cnt++;
        if (overflow_err === 1'b1) ov_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference packing: slice k is bits [k*55 +: 55] of the source, upper
    // 11 bits of the last slice are random filler the receiver must ignore.
    function automatic word_t make_word(input logic [1:0] id, input int idx,
                                        input logic [1:0] ttl, input dfx_t src);
        logic [NUMBER_PACKET*PAYLOAD_WIDTH-1:0] ext;
        ext = {11'($urandom), src};
        return {id, 5'(idx), ttl, ext[idx*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]};
    endfunction

    function automatic dfx_t rand_dfx();
        dfx_t v;
        for (int i = 0; i < DATA_DFX_WIDTH; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic logic [1:0] foreign_id(input logic [1:0] id);
        return id ^ 2'($urandom_range(1, 3));
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input word_t w);
        bus.data_out_port_0 = w;
        bus.data_out_valid  = 1'b1;
        step(1);
        bus.data_out_valid  = 1'b0;
        bus.data_out_port_0 = {$urandom, $urandom};
    endtask

    task automatic send_slices(input logic [1:0] id, input logic [1:0] ttl,
                               input dfx_t src, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send(make_word(id, k, ttl, src));
    endtask

    task automatic mark();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
    endtask

    task automatic check_frame(input string name, input dfx_t exp, input hdr_t exp_hdr);
        total++;
        if (bus.data_dfx_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s valid: got %b want 1", name, bus.data_dfx_valid);
        end
        total++;
        if (bus.data_dfx_recv !== exp) begin
            bad++;
            $display("FAIL %s data: got low=%h high=%h want low=%h high=%h", name,
                     bus.data_dfx_recv[63:0], bus.data_dfx_recv[DATA_DFX_WIDTH-1 -: 64],
                     exp[63:0], exp[DATA_DFX_WIDTH-1 -: 64]);
        end
        total++;
        if (bus.header_pkt_recv !== exp_hdr) begin
            bad++;
            $display("FAIL %s header: got %h want %h", name, bus.header_pkt_recv, exp_hdr);
        end
    endtask

    task automatic check_errs(input string name, input int exp_fe, input int exp_ov);
        step(1);
        total++;
        if ((fe_cnt - fe0) !== exp_fe) begin
            bad++;
            $display("FAIL %s frame_err pulses: got %0d want %0d", name, fe_cnt - fe0, exp_fe);
        end
        total++;
        if ((ov_cnt - ov0) !== exp_ov) begin
            bad++;
            $display("FAIL %s overflow_err pulses: got %0d want %0d", name, ov_cnt - ov0, exp_ov);
        end
    endtask

    task automatic check_valid(input string name, input logic exp);
        total++;
        if (bus.data_dfx_valid !== exp) begin
            bad++;
            $display("FAIL %s valid: got %b want %b", name, bus.data_dfx_valid, exp);
        end
    endtask

    task automatic accept(input string name);
        bus.data_dfx_ready = 1'b1;
        step(1);
        bus.data_dfx_ready = 1'b0;
        check_valid({name, "_after_accept"}, 1'b0);
    endtask

    task automatic check_zero(input string name);
        total++;
        if (bus.data_dfx_valid !== 1'b0 || frame_err !== 1'b0 || overflow_err !== 1'b0) begin
            bad++;
            $display("FAIL %s flags: got valid=%b ferr=%b oerr=%b want 000", name,
                     bus.data_dfx_valid, frame_err, overflow_err);
        end
        total++;
        if (bus.data_dfx_recv !== '0) begin
            bad++;
            $display("FAIL %s data: got low=%h want 0", name, bus.data_dfx_recv[63:0]);
        end
        total++;
        if (bus.header_pkt_recv !== '0) begin
            bad++;
            $display("FAIL %s header: got %h want 0", name, bus.header_pkt_recv);
        end
    endtask

    dfx_t frame_a;

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        step(3);
        check_zero("reset");
        rst_n = 1'b1;
        step(1);
        check_zero("reset_release");
    endtask

    task automatic test_frame_a();
        mark();
        send_slices(2'b01, 2'd2, frame_a, 0, 17);
        check_valid("frameA_before_last", 1'b0);
        send_slices(2'b01, 2'd2, frame_a, 18, 18);
        check_frame("frameA", frame_a, {2'b01, 5'd0, 2'd2});
        check_errs("frameA", 0, 0);
        check_frame("frameA_held", frame_a, {2'b01, 5'd0, 2'd2});
        accept("frameA");
    endtask

    task automatic test_gaps_foreign();
        mark();
        for (int k = 0; k < NUMBER_PACKET; k++) begin
            send(make_word(2'b01, k, 2'd2, frame_a));
            if (k == 5) step(3);
            if (k == 2) send(make_word(2'b10, 0, 2'd1, rand_dfx()));
            if (k == 7) send(make_word(2'b10, 9, 2'd0, rand_dfx()));
            if (k < 18 && $urandom_range(0, 1) == 1)
                send(make_word(2'b10, $urandom_range(0, 31), 2'($urandom), rand_dfx()));
        end
        check_frame("gaps", frame_a, {2'b01, 5'd0, 2'd2});
        check_errs("gaps", 0, 0);
        accept("gaps");
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 4; n++) begin
            logic [1:0] id;
            logic [1:0] ttl;
            dfx_t src;
            id  = 2'($urandom);
            ttl = 2'($urandom_range(0, 2));
            src = rand_dfx();
            local_router_id = id;
            step(1);
            mark();
            for (int k = 0; k < NUMBER_PACKET; k++) begin
                send(make_word(id, k, ttl, src));
                if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
                if (k < 18 && $urandom_range(0, 2) == 0)
                    send(make_word(foreign_id(id), $urandom_range(0, 18), ttl, rand_dfx()));
            end
            check_frame($sformatf("rand%0d", n), src, {id, 5'd0, ttl});
            check_errs($sformatf("rand%0d", n), 0, 0);
            accept($sformatf("rand%0d", n));
        end
        local_router_id = 2'b01;
        step(1);
    endtask

    task automatic test_seq_error();
        dfx_t d;
        dfx_t ones;
        d    = rand_dfx();
        ones = '1;
        mark();
        send_slices(2'b01, 2'd1, d, 0, 6);
        send(make_word(2'b01, 8, 2'd1, d));
        check_errs("seqerr_skip", 1, 0);
        check_valid("seqerr_skip", 1'b0);
        // Back in IDLE, so the once-expected idx 7 is itself out of sequence
        send(make_word(2'b01, 7, 2'd1, d));
        check_errs("seqerr_idle", 2, 0);
        send_slices(2'b01, 2'd0, ones, 0, 18);
        check_frame("seqerr_clean", ones, {2'b01, 5'd0, 2'd0});
        check_errs("seqerr_clean", 2, 0);
        accept("seqerr_clean");
    endtask

    task automatic test_restart();
        dfx_t x;
        dfx_t y;
        x = rand_dfx();
        y = rand_dfx();
        mark();
        send_slices(2'b01, 2'd0, x, 0, 3);
        send_slices(2'b01, 2'd2, y, 0, 18);
        check_frame("restart", y, {2'b01, 5'd0, 2'd2});
        check_errs("restart", 1, 0);
        accept("restart");
    endtask

    task automatic test_back_to_back();
        dfx_t b;
        dfx_t c;
        b = rand_dfx();
        c = rand_dfx();
        mark();
        send_slices(2'b01, 2'd1, b, 0, 18);
        step(2);
        check_frame("bp_full", b, {2'b01, 5'd0, 2'd1});
        send(make_word(2'b11, 0, 2'd2, c));
        check_errs("bp_foreign", 0, 0);
        send(make_word(2'b01, 0, 2'd2, c));
        check_errs("bp_overflow", 0, 1);
        check_frame("bp_held", b, {2'b01, 5'd0, 2'd1});
        bus.data_dfx_ready = 1'b1;
        send(make_word(2'b01, 0, 2'd2, c));
        bus.data_dfx_ready = 1'b0;
        check_valid("bp_handshake", 1'b0);
        send_slices(2'b01, 2'd2, c, 1, 18);
        check_frame("bp_next", c, {2'b01, 5'd0, 2'd2});
        check_errs("bp_next", 0, 1);
        accept("bp_next");
    endtask

    task automatic test_reset_mid();
        dfx_t p;
        dfx_t q;
        p = rand_dfx();
        q = rand_dfx();
        send_slices(2'b01, 2'd1, p, 0, 10);
        #2 rst_n = 1'b0;
        #1;
        check_zero("midreset");
        step(2);
        rst_n = 1'b1;
        step(1);
        mark();
        send_slices(2'b01, 2'd0, q, 0, 18);
        check_frame("midreset_next", q, {2'b01, 5'd0, 2'd0});
        check_errs("midreset_next", 0, 0);
        accept("midreset_next");
    endtask

    initial begin
        bus.data_out_port_0 = '0;
        bus.data_out_valid  = 1'b0;
        bus.data_dfx_ready  = 1'b0;
        local_router_id     = 2'b01;
        frame_a             = {{128{8'hA5}}, 10'h2AA};

        test_reset();
        test_frame_a();
        test_gaps_foreign();
        test_random_frames();
        test_seq_error();
        test_restart();
        test_back_to_back();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
